neuron_mac: RTL and testbench
=============================

NEURON_MAC -- requirements
Module: neuron_mac

Interface
REQ-001 SHALL have parameter N_IN, default 9, meaning number of inputs/weights (>=1).
REQ-002 SHALL have parameter DATA_W, default 33, meaning signed input/output width.
REQ-003 SHALL have parameter WEIGHT_W, default 33, meaning signed weight/bias width.
REQ-004 SHALL have parameter FRAC_BITS, default 26, meaning weight/bias fractional bits (Q format).
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1, meaning reset, asynchronous, active-high.
REQ-007 SHALL have port start, input, 1, meaning request one evaluation.
REQ-008 SHALL have port in_data, input, N_IN*DATA_W, meaning signed inputs with input i at bits [i*DATA_W +: DATA_W].
REQ-009 SHALL have port relu_en, input, 1, meaning ReLU enable.
REQ-010 SHALL have port w_we, input, 1, meaning weight write strobe.
REQ-011 SHALL have port w_addr, input, clog2(N_IN+1), meaning address: 0..N_IN-1 = weight, N_IN = bias.
REQ-012 SHALL have port w_data, input, WEIGHT_W, meaning signed weight/bias value.
REQ-013 SHALL have port busy, output, 1, meaning evaluation in progress.
REQ-014 SHALL have port out, output, DATA_W, meaning signed registered result.
REQ-015 SHALL have port done, output, 1, meaning one-cycle result-valid pulse.

Function
REQ-016 SHALL hold N_IN weights plus one bias in internal registers, written on a clk edge when w_we=1, busy=0 and w_addr<=N_IN.
REQ-017 SHALL ignore writes with w_addr>N_IN and all writes while busy=1.
REQ-018 SHALL implement states IDLE, MAC and OUT; busy is 1 in MAC and OUT, and 0 in IDLE.
REQ-019 SHALL, in IDLE with start=1, latch in_data and relu_en, load acc=sign-extended bias, set index=0, and enter MAC.
REQ-020 SHALL ignore start in MAC and OUT, with no queuing.
REQ-021 SHALL, in MAC, each cycle perform acc += x[index]*w[index] using a full-precision DATA_W+WEIGHT_W product; it increments index and enters OUT after index N_IN-1 (N_IN cycles).
REQ-022 SHALL size acc as DATA_W+WEIGHT_W+clog2(N_IN)+1 bits so it never overflows.
REQ-023 SHALL, in OUT, compute r = acc >>> FRAC_BITS (arithmetic shift, truncation toward minus infinity).
REQ-024 SHALL, in OUT, then set r=0 if relu_en(latched)=1 and r<0.
REQ-025 SHALL, in OUT, then saturate r to [-2^(DATA_W-1), 2^(DATA_W-1)-1], register it to out, pulse done=1 for exactly one cycle, and return to IDLE.
REQ-026 SHALL give a latency, counting start sampled at edge k, of out/done updated at edge k+N_IN+1; start sampled in the done cycle is accepted, giving a back-to-back period of N_IN+1 cycles.
REQ-027 SHALL hold out unchanged between done pulses; in_data changes after the start edge do not affect the result.

Reset
REQ-028 SHALL, while rst=1, immediately force state IDLE, busy=0, done=0, out=0, acc=0, index=0, all weights and bias=0.
REQ-029 SHALL abort an evaluation in progress when rst is asserted mid-evaluation, with no done pulse for it.

Verification
REQ-030 SHALL verify the basic sum: all weights=2^26 (1.0), bias=0, inputs 1..9, relu_en=0, start -> done exactly 10 cycles later with out=45 and busy high for 10 cycles.
REQ-031 SHALL verify ReLU: weights=-2^26, inputs 1..9 -> out=-45 with relu_en=0, and out=0 with relu_en=1.
REQ-032 SHALL verify bias and truncation: weights=0, bias=7*2^26 -> out=7; bias=-(2^25) (-0.5) -> out=-1.
REQ-033 SHALL verify saturation: all inputs=2^32-1, all weights=2^32-1 -> out=4294967295; inputs=-2^32 with the same weights -> out=-4294967296.
REQ-034 SHALL verify busy protection: start pulsed at cycles 3 and 5 of MAC and w_we writes during busy -> a single done and an unchanged result on re-run.
REQ-035 SHALL verify reset mid-operation: rst asserted at MAC cycle 5 -> busy=0, no done; re-run with no weight writes -> out=0.

Source files
------------

// File: rtl/neuron_mac.sv
// Single neuron: N_IN-term multiply-accumulate over stored Q-format weights plus bias,
// followed by arithmetic rescale, optional ReLU and saturation to the output width.

module neuron_mac_wreg #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] q_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q_q <= '0;
    else if (we_i) q_q <= d_i;
  end

  assign q_o = q_q;
endmodule

module neuron_mac #(
  parameter  int N_IN      = 9,
  parameter  int DATA_W    = 33,
  parameter  int WEIGHT_W  = 33,
  parameter  int FRAC_BITS = 26,
  localparam int ADDR_W    = $clog2(N_IN + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [N_IN*DATA_W-1:0]   in_data,
  input  logic                     relu_en,
  input  logic                     w_we,
  input  logic [ADDR_W-1:0]        w_addr,
  input  logic [WEIGHT_W-1:0]      w_data,
  output logic                     busy,
  output logic [DATA_W-1:0]        out,
  output logic                     done
);
  localparam int PROD_W = DATA_W + WEIGHT_W;
  localparam int ACC_W  = PROD_W + $clog2(N_IN) + 1;
  localparam int IDX_W  = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

  state_t                          state_q, state_d;
  logic signed [ACC_W-1:0]         acc_q, acc_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [N_IN-1:0][DATA_W-1:0]     x_q, x_d;
  logic                            relu_q, relu_d;
  logic [DATA_W-1:0]               out_q, out_d;
  logic                            done_q, done_d;

  // Entry N_IN of the register bank is the bias.
  logic [N_IN:0][WEIGHT_W-1:0]     wr_q;

  assign busy = (state_q != S_IDLE);
  assign out  = out_q;
  assign done = done_q;

  for (genvar gi = 0; gi <= N_IN; gi++) begin : g_wreg
    neuron_mac_wreg #(.W(WEIGHT_W)) u_wreg (
      .clk  (clk),
      .rst  (rst),
      .we_i (w_we && !busy && (w_addr == ADDR_W'(gi))),
      .d_i  (w_data),
      .q_o  (wr_q[gi])
    );
  end

  logic signed [DATA_W-1:0]   x_sel;
  logic signed [WEIGHT_W-1:0] w_sel;
  logic signed [WEIGHT_W-1:0] bias_s;
  logic signed [PROD_W-1:0]   prod;
  logic signed [ACC_W-1:0]    prod_ext, bias_ext, shifted, res;
  logic [DATA_W-1:0]          sat;

  always_comb begin
    x_sel    = x_q[idx_q];
    w_sel    = wr_q[idx_q];
    bias_s   = wr_q[N_IN];
    prod     = PROD_W'(x_sel) * PROD_W'(w_sel);
    prod_ext = ACC_W'(prod);
    bias_ext = ACC_W'(bias_s);
  end

  // Rescale out of Q format, then ReLU, then clamp into the signed output range.
  always_comb begin
    shifted = acc_q >>> FRAC_BITS;
    res     = shifted;
    if (relu_q && (res < 0)) res = '0;
    if (res > SAT_MAX)      sat = {1'b0, {(DATA_W-1){1'b1}}};
    else if (res < SAT_MIN) sat = {1'b1, {(DATA_W-1){1'b0}}};
    else                    sat = res[DATA_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    x_d     = x_q;
    relu_d  = relu_q;
    out_d   = out_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d     = in_data;
          relu_d  = relu_en;
          acc_d   = bias_ext;
          idx_d   = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = acc_q + prod_ext;
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) state_d = S_OUT;
      end
      S_OUT: begin
        out_d   = sat;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      idx_q   <= '0;
      x_q     <= '0;
      relu_q  <= 1'b0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      relu_q  <= relu_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac: scoreboard of expected results, checked on each done pulse.

module tb_neuron_mac;
  localparam int N_IN      = 9;
  localparam int DATA_W    = 33;
  localparam int WEIGHT_W  = 33;
  localparam int FRAC_BITS = 26;
  localparam int AW        = $clog2(N_IN + 1);

  localparam logic [WEIGHT_W-1:0] ONE     = WEIGHT_W'(1) << FRAC_BITS;
  localparam logic [WEIGHT_W-1:0] NEG_ONE = -(WEIGHT_W'(1) << FRAC_BITS);
  localparam logic [WEIGHT_W-1:0] BIAS7   = WEIGHT_W'(7) << FRAC_BITS;
  localparam logic [WEIGHT_W-1:0] NEG_HLF = -(WEIGHT_W'(1) << (FRAC_BITS - 1));
  localparam logic [WEIGHT_W-1:0] BIGW    = 33'h0FFFFFFFF;
  localparam logic [DATA_W-1:0]   MAXV    = 33'h0FFFFFFFF;
  localparam logic [DATA_W-1:0]   MINV    = 33'h100000000;

  logic                   clk = 1'b0;
  logic                   rst, start, relu_en, w_we, busy, done;
  logic [N_IN*DATA_W-1:0] in_data;
  logic [AW-1:0]          w_addr;
  logic [WEIGHT_W-1:0]    w_data;
  logic [DATA_W-1:0]      out;

  neuron_mac #(.N_IN(N_IN), .DATA_W(DATA_W), .WEIGHT_W(WEIGHT_W), .FRAC_BITS(FRAC_BITS)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .relu_en(relu_en),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .busy(busy), .out(out), .done(done)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0, done_cnt = 0;
  logic done_prev = 1'b0;
  logic [DATA_W-1:0] sb[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Result checker: every done pulse consumes one scoreboard entry.
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      check("done_one_cycle", 64'(done_prev), 64'd0);
      check("sb_nonempty", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) check("result", 64'(out), 64'(sb.pop_front()));
    end
    done_prev = done;
  end

  function automatic logic [N_IN*DATA_W-1:0] seq_x();
    logic [N_IN*DATA_W-1:0] r;
    for (int i = 0; i < N_IN; i++) r[i*DATA_W +: DATA_W] = DATA_W'(i + 1);
    return r;
  endfunction

  function automatic logic [N_IN*DATA_W-1:0] all_x(input logic [DATA_W-1:0] v);
    logic [N_IN*DATA_W-1:0] r;
    for (int i = 0; i < N_IN; i++) r[i*DATA_W +: DATA_W] = v;
    return r;
  endfunction

  task automatic wr(input int a, input logic [WEIGHT_W-1:0] d);
    w_we = 1'b1; w_addr = AW'(a); w_data = d;
    @(negedge clk);
    w_we = 1'b0;
  endtask

  task automatic set_w(input logic [WEIGHT_W-1:0] w, input logic [WEIGHT_W-1:0] b);
    for (int i = 0; i < N_IN; i++) wr(i, w);
    wr(N_IN, b);
  endtask

  // Called at a negedge; returns at the negedge where done is seen (the done cycle).
  task automatic run(input logic [N_IN*DATA_W-1:0] x, input logic relu,
                     input logic [DATA_W-1:0] exp, input string tag);
    int cyc = 0, bcnt = 0;
    in_data = x; relu_en = relu; start = 1'b1;
    sb.push_back(exp);
    do begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (busy) bcnt++;
    end while (!done && cyc < 40);
    check({tag, "_latency"}, 64'(cyc - 1), 64'(N_IN + 1));
    check({tag, "_busy_cycles"}, 64'(bcnt), 64'(N_IN + 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    rst = 1'b1; start = 1'b0; relu_en = 1'b0; w_we = 1'b0; w_addr = '0; w_data = '0; in_data = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_out",  64'(out),  64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic sum, then a back-to-back start in the done cycle.
    set_w(ONE, '0);
    run(seq_x(), 1'b0, 33'd45, "basic");
    run(seq_x(), 1'b0, 33'd45, "b2b");
    @(negedge clk);

    set_w(NEG_ONE, '0);
    run(seq_x(), 1'b0, -33'sd45, "neg");
    run(seq_x(), 1'b1, 33'd0, "relu");

    // Bias only, truncation toward minus infinity, out-of-range address ignored.
    set_w('0, BIAS7);
    wr(15, 33'h0DEADBEEF);
    run(seq_x(), 1'b0, 33'd7, "bias7");
    @(negedge clk);
    wr(N_IN, NEG_HLF);
    run(seq_x(), 1'b0, -33'sd1, "trunc");

    set_w(BIGW, '0);
    run(all_x(MAXV), 1'b0, MAXV, "sat_pos");
    run(all_x(MINV), 1'b0, MINV, "sat_neg");
    @(negedge clk);

    // Starts and weight writes while busy are ignored; in_data changes are ignored.
    set_w(ONE, '0);
    d0 = done_cnt;
    in_data = seq_x(); relu_en = 1'b0; start = 1'b1;
    sb.push_back(33'd45);
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      start = (c == 3 || c == 5);
      if (c == 3) in_data = all_x(33'd3);
      w_we   = (c == 3 || c == 5 || c == 7);
      w_addr = (c == 7) ? AW'(N_IN) : AW'(0);
      w_data = 33'h07FFFFFFF;
    end
    start = 1'b0; w_we = 1'b0;
    check("busy_single_done", 64'(done_cnt - d0), 64'd1);
    check("out_hold", 64'(out), 64'd45);
    run(seq_x(), 1'b0, 33'd45, "rerun");
    @(negedge clk);

    // Reset mid-evaluation: abort without done, weights cleared.
    d0 = done_cnt;
    in_data = seq_x(); start = 1'b1;
    repeat (5) begin @(negedge clk); start = 1'b0; end
    rst = 1'b1;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_out",  64'(out),  64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    check("midrst_no_done", 64'(done_cnt - d0), 64'd0);
    run(seq_x(), 1'b0, 33'd0, "post_rst");
    repeat (3) @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
